// File: rtl/ex_stage_unit.sv
// ex_stage_unit
//   Execute stage fed by the ID/EX pipeline register. It selects operands,
//   runs the ALU, computes the branch target and picks the destination
//   register. Multiplies go through an iterative shift-add multiplier that
//   takes one operand bit per cycle and stalls upstream while it runs.
//   Results, controls and out_valid are registered toward EX/MEM.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, flush       ID/EX slot valid; synchronous kill of current work
//   pc_4, reg1, reg2,     instruction operands and fields
//   sign_extend, rt, rd
//   RegWrite..Branch      control bits, registered through to the *_o outputs
//   ALUSrc, RegDest       operand B select / destination register select
//   ALUOp                 3-bit operation code
//   stall_out             upstream must hold ID/EX contents
//   out_valid             EX/MEM slot valid
//   alu_result, zero      result and result==0
//   branch_target         pc_4 + (sign_extend << 2)
//   store_data, write_reg rt data pass-through, destination register
//
// state | meaning
// IDLE  | single-cycle ops complete here; a mul is accepted from here
// MUL   | iterating the multiplier; ID/EX inputs are ignored
module ex_stage_unit #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        flush,
  input  logic [31:0] pc_4,
  input  logic [31:0] reg1,
  input  logic [31:0] reg2,
  input  logic [31:0] sign_extend,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic        RegWrite,
  input  logic        MemToReg,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        Branch,
  input  logic        ALUSrc,
  input  logic        RegDest,
  input  logic [2:0]  ALUOp,
  output logic        stall_out,
  output logic        out_valid,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic [31:0] branch_target,
  output logic [31:0] store_data,
  output logic [4:0]  write_reg,
  output logic        RegWrite_o,
  output logic        MemToReg_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic        Branch_o
);

  typedef enum logic {IDLE, MUL} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SLL = 3'b111;

  localparam logic [4:0] LAST_CNT = 5'(MUL_CYCLES - 1);

  state_t      state, state_nx;
  logic [31:0] op_b;
  logic [31:0] alu_comb;
  logic [31:0] bt_comb;
  logic [4:0]  wr_comb;
  logic [4:0]  ctl_in;
  logic        is_mul;
  logic        mul_accept;

  logic [31:0] ma, mb, acc;
  logic [4:0]  count;
  logic [31:0] mul_sum;
  logic [31:0] lat_bt, lat_sd;
  logic [4:0]  lat_wr, lat_ctl;
  logic [4:0]  ctl_q;

  assign op_b       = ALUSrc ? sign_extend : reg2;
  assign is_mul     = (ALUOp == OP_MUL);
  assign mul_accept = in_valid && is_mul && !flush;
  assign bt_comb    = pc_4 + {sign_extend[29:0], 2'b00};
  assign wr_comb    = RegDest ? rd : rt;
  assign ctl_in     = {RegWrite, MemToReg, MemRead, MemWrite, Branch};
  // The final iteration's partial product is folded in combinationally so
  // the product is written on the same edge as the last shift-add step.
  assign mul_sum    = acc + (mb[0] ? ma : 32'd0);

  always_comb begin
    alu_comb = 32'd0;
    case (ALUOp)
      OP_ADD: alu_comb = reg1 + op_b;
      OP_SUB: alu_comb = reg1 - op_b;
      OP_AND: alu_comb = reg1 & op_b;
      OP_OR:  alu_comb = reg1 | op_b;
      OP_SLT: alu_comb = {31'd0, ($signed(reg1) < $signed(op_b))};
      OP_NOR: alu_comb = ~(reg1 | op_b);
      OP_MUL: alu_comb = 32'd0;
      OP_SLL: alu_comb = op_b << sign_extend[10:6];
      default: alu_comb = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    stall_out = 1'b0;
    case (state)
      IDLE: begin
        if (mul_accept) begin
          stall_out = 1'b1;
          state_nx  = MUL;
        end
      end
      MUL: begin
        // Releasing the stall on the last iteration lets upstream advance
        // on the same edge that the product is written.
        stall_out = (count != LAST_CNT);
        if (flush || count == LAST_CNT) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      alu_result    <= 32'd0;
      zero          <= 1'b0;
      branch_target <= 32'd0;
      store_data    <= 32'd0;
      write_reg     <= 5'd0;
      ctl_q         <= 5'd0;
      ma            <= 32'd0;
      mb            <= 32'd0;
      acc           <= 32'd0;
      count         <= 5'd0;
      lat_bt        <= 32'd0;
      lat_sd        <= 32'd0;
      lat_wr        <= 5'd0;
      lat_ctl       <= 5'd0;
    end else if (flush) begin
      out_valid <= 1'b0;
      ctl_q     <= 5'd0;
      count     <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && is_mul) begin
            ma        <= reg1;
            mb        <= op_b;
            acc       <= 32'd0;
            count     <= 5'd0;
            lat_bt    <= bt_comb;
            lat_sd    <= reg2;
            lat_wr    <= wr_comb;
            lat_ctl   <= ctl_in;
            out_valid <= 1'b0;
            ctl_q     <= 5'd0;
          end else if (in_valid) begin
            alu_result    <= alu_comb;
            zero          <= (alu_comb == 32'd0);
            branch_target <= bt_comb;
            store_data    <= reg2;
            write_reg     <= wr_comb;
            ctl_q         <= ctl_in;
            out_valid     <= 1'b1;
          end else begin
            out_valid <= 1'b0;
            ctl_q     <= 5'd0;
          end
        end
        MUL: begin
          acc   <= mul_sum;
          ma    <= ma << 1;
          mb    <= mb >> 1;
          count <= count + 5'd1;
          if (count == LAST_CNT) begin
            alu_result    <= mul_sum;
            zero          <= (mul_sum == 32'd0);
            branch_target <= lat_bt;
            store_data    <= lat_sd;
            write_reg     <= lat_wr;
            ctl_q         <= lat_ctl;
            out_valid     <= 1'b1;
          end else begin
            out_valid <= 1'b0;
            ctl_q     <= 5'd0;
          end
        end
        default: begin
          out_valid <= 1'b0;
          ctl_q     <= 5'd0;
        end
      endcase
    end
  end

  assign {RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, Branch_o} = ctl_q;

endmodule

// File: tb/tb_ex_stage_unit.sv
module tb_ex_stage_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, flush;
  logic [31:0] pc_4, reg1, reg2, sign_extend;
  logic [4:0]  rt, rd;
  logic        RegWrite, MemToReg, MemRead, MemWrite, Branch;
  logic        ALUSrc, RegDest;
  logic [2:0]  ALUOp;
  logic        stall_out, out_valid, zero;
  logic [31:0] alu_result, branch_target, store_data;
  logic [4:0]  write_reg;
  logic        RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, Branch_o;

  ex_stage_unit #(.MUL_CYCLES(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .flush(flush),
    .pc_4(pc_4), .reg1(reg1), .reg2(reg2), .sign_extend(sign_extend),
    .rt(rt), .rd(rd), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
    .ALUSrc(ALUSrc), .RegDest(RegDest), .ALUOp(ALUOp),
    .stall_out(stall_out), .out_valid(out_valid), .alu_result(alu_result),
    .zero(zero), .branch_target(branch_target), .store_data(store_data),
    .write_reg(write_reg), .RegWrite_o(RegWrite_o), .MemToReg_o(MemToReg_o),
    .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .Branch_o(Branch_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic [31:0] bt;
    logic [31:0] sd;
    logic [4:0]  wr;
    logic [4:0]  ctl;
    int          edge_no;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   edge_cnt = 0;

  always @(posedge clk) edge_cnt++;

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    logic [63:0] p;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5: return ~(a | b);
      3'd6: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      default: return b << sh;
    endcase
  endfunction

  function automatic logic [4:0] ctl_out();
    return {RegWrite_o, MemToReg_o, MemRead_o, MemWrite_o, Branch_o};
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_out_valid at edge %0d: result=%h (no expected entry)", edge_cnt, alu_result);
        end else begin
          e = exp_q.pop_front();
          n_vec++;
          if (alu_result !== e.res || zero !== e.z) begin
            n_fail++;
            $display("FAIL result: got %h zero=%b, want %h zero=%b", alu_result, zero, e.res, e.z);
          end
          n_vec++;
          if (branch_target !== e.bt || store_data !== e.sd || write_reg !== e.wr || ctl_out() !== e.ctl) begin
            n_fail++;
            $display("FAIL fields: got bt=%h sd=%h wr=%0d ctl=%b, want bt=%h sd=%h wr=%0d ctl=%b",
                     branch_target, store_data, write_reg, ctl_out(), e.bt, e.sd, e.wr, e.ctl);
          end
          n_vec++;
          if (edge_cnt != e.edge_no) begin
            n_fail++;
            $display("FAIL latency: result at edge %0d, want edge %0d", edge_cnt, e.edge_no);
          end
        end
      end else begin
        n_vec++;
        if (ctl_out() !== 5'd0) begin
          n_fail++;
          $display("FAIL ctl_without_valid: ctl=%b, want 00000", ctl_out());
        end
      end
    end
  end

  task automatic set_instr(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic [31:0] pc,
                           input logic [4:0] rt_i, input logic [4:0] rd_i,
                           input logic alusrc, input logic regdest, input logic [4:0] ctl);
    in_valid = 1'b1; ALUOp = op; reg1 = a; reg2 = b; sign_extend = imm; pc_4 = pc;
    rt = rt_i; rd = rd_i; ALUSrc = alusrc; RegDest = regdest;
    {RegWrite, MemToReg, MemRead, MemWrite, Branch} = ctl;
  endtask

  // Called about 1 time unit after a rising edge. Presents the instruction,
  // records the expected outcome, and holds it until the DUT consumes it.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [31:0] pc,
                       input logic [4:0] rt_i, input logic [4:0] rd_i,
                       input logic alusrc, input logic regdest, input logic [4:0] ctl);
    exp_t e;
    int   stalls;
    logic [31:0] bval;
    set_instr(op, a, b, imm, pc, rt_i, rd_i, alusrc, regdest, ctl);
    bval      = alusrc ? imm : b;
    e.res     = ref_alu(op, a, bval, imm[10:6]);
    e.z       = (e.res == 32'd0);
    e.bt      = pc + imm * 4;
    e.sd      = b;
    e.wr      = regdest ? rd_i : rt_i;
    e.ctl     = ctl;
    e.edge_no = edge_cnt + ((op == 3'd6) ? 33 : 1);
    exp_q.push_back(e);
    #1;
    stalls = 0;
    while (stall_out === 1'b1 && stalls < 40) begin
      stalls++;
      @(posedge clk);
      #2;
    end
    n_vec++;
    if (stalls != ((op == 3'd6) ? 32 : 0)) begin
      n_fail++;
      $display("FAIL stall_cycles op=%0d: got %0d, want %0d", op, stalls, (op == 3'd6) ? 32 : 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      reg1 = $urandom; reg2 = $urandom; ALUOp = 3'($urandom);
      {RegWrite, MemToReg, MemRead, MemWrite, Branch} = 5'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero_outputs(input string name);
    n_vec++;
    if ({out_valid, alu_result, zero, branch_target, store_data, write_reg, ctl_out()} !== '0) begin
      n_fail++;
      $display("FAIL %s: got valid=%b res=%h z=%b bt=%h sd=%h wr=%0d ctl=%b, want all 0",
               name, out_valid, alu_result, zero, branch_target, store_data, write_reg, ctl_out());
    end
  endtask

  task automatic mul_to_count10();
    set_instr(3'd6, 32'h1234, 32'h10, 32'h0, 32'h40, 5'd1, 5'd2, 1'b0, 1'b1, 5'b10000);
    repeat (11) @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b, imm;
    logic [2:0]  op;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    set_instr(3'd0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 5'd0);
    in_valid = 1'b0;
    #12;
    check_zero_outputs("reset_outputs");
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(3'd0, 32'd5, 32'd7, 32'h0, 32'h0, 5'd0, 5'd3, 1'b0, 1'b1, 5'b10000);
    n_vec++;
    if (stall_out !== 1'b0) begin
      n_fail++; $display("FAIL add_stall: got %b, want 0", stall_out);
    end
    issue(3'd1, 32'd9, 32'd9, 32'hFFFF_FFFE, 32'h100, 5'd4, 5'd5, 1'b0, 1'b1, 5'b00001);
    issue(3'd4, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'h200, 5'd8, 5'd9, 1'b1, 1'b0, 5'b10000);
    issue(3'd6, 32'h1234, 32'h10, 32'h0, 32'h300, 5'd1, 5'd6, 1'b0, 1'b1, 5'b10000);
    issue(3'd6, 32'h10000, 32'h10000, 32'h0, 32'h304, 5'd1, 5'd7, 1'b0, 1'b1, 5'b11000);
    issue(3'd7, 32'h0, 32'h0, 32'h0000_0105, 32'h308, 5'd2, 5'd3, 1'b1, 1'b0, 5'b10000);
    issue(3'd6, 32'hFFFF_FFFD, 32'd7, 32'h0, 32'h30C, 5'd1, 5'd2, 1'b0, 1'b1, 5'b10000);

    for (int i = 0; i < 60; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4)) : $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      imm = $urandom;
      issue(op, a, b, imm, $urandom, 5'($urandom), 5'($urandom),
            1'($urandom), 1'($urandom), 5'($urandom));
      if ($urandom_range(0, 2) == 0) bubbles($urandom_range(1, 3));
    end

    // flush mid-multiply
    mul_to_count10();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_vec++;
    if (stall_out !== 1'b0 || out_valid !== 1'b0 || RegWrite_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_mul: got stall=%b valid=%b regwrite=%b, want 0 0 0", stall_out, out_valid, RegWrite_o);
    end
    issue(3'd0, 32'd1, 32'd2, 32'h0, 32'h0, 5'd1, 5'd4, 1'b0, 1'b1, 5'b10000);

    // flush in IDLE kills a presented mul and drops the stall
    set_instr(3'd6, 32'd3, 32'd3, 32'h0, 32'h0, 5'd1, 5'd2, 1'b0, 1'b1, 5'b10000);
    flush = 1'b1;
    #1;
    n_vec++;
    if (stall_out !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle_stall: got %b, want 0", stall_out);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    bubbles(3);

    // reset mid-multiply
    mul_to_count10();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("reset_mid_mul");
    #3;
    rst_n = 1'b1;
    bubbles(40);
    issue(3'd3, 32'hF0, 32'h0F, 32'h0, 32'h10, 5'd1, 5'd2, 1'b0, 1'b0, 5'b10100);
    bubbles(2);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL leftover_expected: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1);
  end

endmodule
